// File: rtl/op_tx_scheduler.sv
// Purpose: arbitrates power-on / mic / keyboard opcode packets and serialises the
//          winning 40-bit packet MSB-first on an idle-high line with start bit and gap.
// Latency: ack and start bit appear the cycle after the IDLE grant edge; frame is
//          (41+GAP_BITS)*BIT_CLKS cycles from capture to IDLE.
// Backpressure: requesters hold req until their one-cycle ack; no grants outside IDLE.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   poweron_req                   level; each rising edge requests one power-on packet
//   kbd_req/kbd_is_mouse/kbd_data keyboard/mouse request and payload, kbd_ack pulse out
//   mic_req/mic_data              microphone request and payload, mic_ack pulse out
//   tx_out                        serial line (idle high)
//   busy                          high whenever a frame is in progress
//   last_src                      0 none, 1 power-on, 2 mic, 3 kbd
module op_tx_scheduler #(
  parameter int BIT_CLKS = 4,
  parameter int GAP_BITS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        poweron_req,
  input  logic        kbd_req,
  input  logic        kbd_is_mouse,
  input  logic [15:0] kbd_data,
  output logic        kbd_ack,
  input  logic        mic_req,
  input  logic [31:0] mic_data,
  output logic        mic_ack,
  output logic        tx_out,
  output logic        busy,
  output logic [1:0]  last_src
);

  localparam int              GAP_CLKS = GAP_BITS * BIT_CLKS;
  localparam int              GW       = $clog2(GAP_CLKS + 1);
  localparam logic [7:0]      BIT_LAST = 8'(BIT_CLKS - 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CLKS - 1);
  localparam logic [5:0]      BIT_MAX  = 6'd39;

  typedef enum logic [1:0] {IDLE, START, DATA, GAP} state_t;

  state_t        state;
  state_t        state_nxt;

  logic [39:0]   shift;
  logic [7:0]    bit_tmr;
  logic [5:0]    bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic          po_q;
  logic          po_pend;
  logic          rr_mic;     // 1: mic wins a mic/kbd tie

  logic          po_rise;
  logic          po_want;
  logic          gnt_po;
  logic          gnt_mic;
  logic          gnt_kbd;
  logic          grant;
  logic          bit_end;
  logic [39:0]   pkt;

  assign po_rise = poweron_req & ~po_q;
  // Include the edge seen this cycle so a power-on rising together with
  // other requests still wins immediately.
  assign po_want = po_pend | po_rise;
  assign bit_end = (bit_tmr == BIT_LAST);
  assign grant   = gnt_po | gnt_mic | gnt_kbd;
  assign busy    = (state != IDLE);

  // Arbitration, only meaningful in IDLE
  always_comb begin
    gnt_po  = 1'b0;
    gnt_mic = 1'b0;
    gnt_kbd = 1'b0;
    if (state == IDLE) begin
      if (po_want) begin
        gnt_po = 1'b1;
      end else if (mic_req && kbd_req) begin
        gnt_mic = rr_mic;
        gnt_kbd = ~rr_mic;
      end else begin
        gnt_mic = mic_req;
        gnt_kbd = kbd_req;
      end
    end
  end

  // Packet builder for the winner
  always_comb begin
    pkt = 40'hC671000000;
    if (gnt_mic) begin
      pkt = {8'hC7, mic_data};
    end else if (gnt_kbd) begin
      pkt = {8'hC6, (kbd_is_mouse ? 8'h01 : 8'h10), 8'h00, kbd_data};
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and line output; tx_out decodes registered state only,
  // so reset forces the line high without waiting for a clock.
  always_comb begin
    state_nxt = state;
    tx_out    = 1'b1;
    unique case (state)
      IDLE: begin
        if (grant) state_nxt = START;
      end
      START: begin
        tx_out = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        tx_out = shift[39];
        if (bit_end && (bit_cnt == BIT_MAX)) state_nxt = GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: edge detect, pointer, acks, shifter and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      po_q     <= 1'b0;
      po_pend  <= 1'b0;
      rr_mic   <= 1'b1;
      kbd_ack  <= 1'b0;
      mic_ack  <= 1'b0;
      last_src <= 2'd0;
      shift    <= 40'd0;
      bit_tmr  <= 8'd0;
      bit_cnt  <= 6'd0;
      gap_cnt  <= '0;
    end else begin
      po_q <= poweron_req;

      // A grant consumes any edges collected so far, including this cycle's
      if (gnt_po) begin
        po_pend <= 1'b0;
      end else if (po_rise) begin
        po_pend <= 1'b1;
      end

      kbd_ack <= gnt_kbd;
      mic_ack <= gnt_mic;

      if (gnt_mic) begin
        rr_mic <= 1'b0;
      end else if (gnt_kbd) begin
        rr_mic <= 1'b1;
      end

      if (grant) begin
        shift    <= pkt;
        last_src <= gnt_po ? 2'd1 : (gnt_mic ? 2'd2 : 2'd3);
      end else if ((state == DATA) && bit_end) begin
        shift <= {shift[38:0], 1'b0};
      end

      if ((state == START) || (state == DATA)) begin
        bit_tmr <= bit_end ? 8'd0 : bit_tmr + 8'd1;
      end else begin
        bit_tmr <= 8'd0;
      end

      if (state == DATA) begin
        if (bit_end) begin
          bit_cnt <= (bit_cnt == BIT_MAX) ? 6'd0 : bit_cnt + 6'd1;
        end
      end else begin
        bit_cnt <= 6'd0;
      end

      if (state == GAP) begin
        gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + GW'(1);
      end else begin
        gap_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_op_tx_scheduler.sv
// Purpose: self-checking bench for op_tx_scheduler; independent serial decoder
//          compares every frame against a scoreboard of expected packets/sources.
// Stimulus is driven on the falling clock edge; outputs are sampled there too.
module tb_op_tx_scheduler;

  localparam int BIT_CLKS   = 4;
  localparam int GAP_BITS   = 2;
  localparam int FRAME_CLKS = (41 + GAP_BITS) * BIT_CLKS;  // 172
  localparam int SPACING    = FRAME_CLKS + 1;              // 173

  localparam logic [1:0] SRC_PO  = 2'd1;
  localparam logic [1:0] SRC_MIC = 2'd2;
  localparam logic [1:0] SRC_KBD = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        poweron_req;
  logic        kbd_req;
  logic        kbd_is_mouse;
  logic [15:0] kbd_data;
  logic        kbd_ack;
  logic        mic_req;
  logic [31:0] mic_data;
  logic        mic_ack;
  logic        tx_out;
  logic        busy;
  logic [1:0]  last_src;

  op_tx_scheduler #(.BIT_CLKS(BIT_CLKS), .GAP_BITS(GAP_BITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .poweron_req  (poweron_req),
    .kbd_req      (kbd_req),
    .kbd_is_mouse (kbd_is_mouse),
    .kbd_data     (kbd_data),
    .kbd_ack      (kbd_ack),
    .mic_req      (mic_req),
    .mic_data     (mic_data),
    .mic_ack      (mic_ack),
    .tx_out       (tx_out),
    .busy         (busy),
    .last_src     (last_src)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [39:0] pkt;
    logic [1:0]  src;
  } exp_t;

  typedef struct {
    logic [1:0]  src;
    logic        mouse;
    logic [31:0] data;
    logic [39:0] pkt;
  } vec_t;

  exp_t exp_q[$];
  int   starts[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   frames_done = 0;
  int   n_aborted = 0;
  int   n_kbd_ack = 0;
  int   n_mic_ack = 0;
  int   exp_kbd_acks = 0;
  int   exp_mic_acks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (kbd_ack === 1'b1) n_kbd_ack <= n_kbd_ack + 1;
    if (mic_ack === 1'b1) n_mic_ack <= n_mic_ack + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_ack(input bit want_mic, input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((want_mic ? mic_ack : kbd_ack) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (frames_done >= target) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(name, 64'(done), 64'd1);
  endtask

  // Serial decoder: c=0 is the first start-bit cycle (the cycle after capture)
  initial begin : monitor
    logic [39:0] word;
    bit          ok;
    bit          aborted;
    bit          have_exp;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || tx_out !== 1'b0) continue;
      starts.push_back(cyc);
      have_exp = (exp_q.size() != 0);
      chk("frame_expected", 64'(have_exp), 64'd1);
      e = have_exp ? exp_q.pop_front() : '0;
      chk("start_kbd_ack", 64'(kbd_ack), 64'(e.src == SRC_KBD));
      chk("start_mic_ack", 64'(mic_ack), 64'(e.src == SRC_MIC));
      chk("start_last_src", 64'(last_src), 64'(e.src));
      chk("start_busy", 64'(busy), 64'd1);
      word    = '0;
      ok      = 1'b1;
      aborted = 1'b0;
      for (int c = 1; c <= FRAME_CLKS; c++) begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
          aborted = 1'b1;
          break;
        end
        if (c == 1) ok &= (kbd_ack === 1'b0) && (mic_ack === 1'b0);
        if (c < BIT_CLKS) begin
          ok &= (tx_out === 1'b0) && (busy === 1'b1);
        end else if (c < 41 * BIT_CLKS) begin
          if (c % BIT_CLKS == 0) word = {word[38:0], tx_out};
          else ok &= (tx_out === word[0]);
          ok &= (busy === 1'b1);
        end else if (c < FRAME_CLKS) begin
          ok &= (tx_out === 1'b1) && (busy === 1'b1);
        end else begin
          ok &= (tx_out === 1'b1) && (busy === 1'b0);
        end
      end
      if (aborted) begin
        n_aborted++;
      end else begin
        chk("frame_pkt", 64'(word), 64'(e.pkt));
        chk("frame_timing", 64'(ok), 64'd1);
        frames_done++;
      end
    end
  end

  initial begin : watchdog
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t vt[8];
    exp_t e;
    int   nf;
    int   sidx;
    bit   line_ok;

    vt[0] = '{SRC_KBD, 1'b0, 32'h0000_1234, 40'hC610001234};
    vt[1] = '{SRC_KBD, 1'b1, 32'h0000_FF01, 40'hC60100FF01};
    vt[2] = '{SRC_MIC, 1'b0, 32'hDEAD_BEEF, 40'hC7DEADBEEF};
    vt[3] = '{SRC_PO,  1'b0, 32'h0000_0000, 40'hC671000000};
    vt[4] = '{SRC_KBD, 1'b0, 32'h0000_ABCD, 40'hC61000ABCD};
    vt[5] = '{SRC_MIC, 1'b0, 32'h0000_0001, 40'hC700000001};
    vt[6] = '{SRC_MIC, 1'b0, 32'hFFFF_FFFF, 40'hC7FFFFFFFF};
    vt[7] = '{SRC_KBD, 1'b1, 32'h0000_0000, 40'hC601000000};

    rst_n        = 1'b0;
    poweron_req  = 1'b0;
    kbd_req      = 1'b0;
    kbd_is_mouse = 1'b0;
    kbd_data     = '0;
    mic_req      = 1'b0;
    mic_data     = '0;
    nf           = 0;

    repeat (3) @(negedge clk);
    chk("rst_tx_out", 64'(tx_out), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_kbd_ack", 64'(kbd_ack), 64'd0);
    chk("rst_mic_ack", 64'(mic_ack), 64'd0);
    chk("rst_last_src", 64'(last_src), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // Table-driven single-source frames
    for (int i = 0; i < 8; i++) begin
      e.pkt = vt[i].pkt;
      e.src = vt[i].src;
      exp_q.push_back(e);
      if (vt[i].src == SRC_MIC) begin
        mic_data = vt[i].data;
        mic_req  = 1'b1;
        exp_mic_acks++;
      end else if (vt[i].src == SRC_KBD) begin
        kbd_data     = vt[i].data[15:0];
        kbd_is_mouse = vt[i].mouse;
        kbd_req      = 1'b1;
        exp_kbd_acks++;
      end else begin
        poweron_req = 1'b1;
      end
      if (vt[i].src == SRC_PO) begin
        repeat (3) @(negedge clk);
        poweron_req = 1'b0;
      end else begin
        wait_ack(vt[i].src == SRC_MIC, 50, "vec_ack");
        mic_req = 1'b0;
        kbd_req = 1'b0;
      end
      nf++;
      wait_frames(nf, 400, "vec_frame");
      chk("vec_last_src", 64'(last_src), 64'(vt[i].src));
    end

    // Power-on priority over simultaneous mic+kbd; pointer back to mic-first
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mic_data     = 32'h0102_0304;
    kbd_data     = 16'h5566;
    kbd_is_mouse = 1'b0;
    e = '{40'hC671000000, SRC_PO};  exp_q.push_back(e);
    e = '{40'hC701020304, SRC_MIC}; exp_q.push_back(e);
    e = '{40'hC610005566, SRC_KBD}; exp_q.push_back(e);
    exp_mic_acks++;
    exp_kbd_acks++;
    sidx = starts.size();
    poweron_req = 1'b1;
    mic_req     = 1'b1;
    kbd_req     = 1'b1;
    wait_ack(1'b1, 600, "prio_mic_ack");
    mic_req     = 1'b0;
    poweron_req = 1'b0;
    wait_ack(1'b0, 600, "prio_kbd_ack");
    kbd_req = 1'b0;
    nf += 3;
    wait_frames(nf, 400, "prio_frames");
    chk("prio_spacing", 64'(starts[sidx+1] - starts[sidx]), 64'(SPACING));

    // Round-robin with both held and data changing after each ack
    mic_data = 32'hA0A0_0001;
    kbd_data = 16'h0B01;
    e = '{40'hC7A0A00001, SRC_MIC}; exp_q.push_back(e);
    e = '{40'hC610000B01, SRC_KBD}; exp_q.push_back(e);
    e = '{40'hC7A0A00002, SRC_MIC}; exp_q.push_back(e);
    e = '{40'hC610000B02, SRC_KBD}; exp_q.push_back(e);
    exp_mic_acks += 2;
    exp_kbd_acks += 2;
    sidx = starts.size();
    mic_req = 1'b1;
    kbd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(k % 2 == 0, 400, "rr_ack");
      if (k % 2 == 0) mic_data = mic_data + 32'd1;
      else            kbd_data = kbd_data + 16'd1;
      if (k == 3) begin
        mic_req = 1'b0;
        kbd_req = 1'b0;
      end
    end
    nf += 4;
    wait_frames(nf, 400, "rr_frames");
    for (int k = 0; k < 3; k++) begin
      chk("rr_spacing", 64'(starts[sidx+k+1] - starts[sidx+k]), 64'(SPACING));
    end

    // Two power-on pulses during a mic frame collapse to one power-on frame
    mic_data = 32'h1357_9BDF;
    e = '{40'hC713579BDF, SRC_MIC}; exp_q.push_back(e);
    e = '{40'hC671000000, SRC_PO};  exp_q.push_back(e);
    exp_mic_acks++;
    mic_req = 1'b1;
    wait_ack(1'b1, 50, "poedge_mic_ack");
    mic_req = 1'b0;
    repeat (20) @(negedge clk);
    poweron_req = 1'b1;
    repeat (2) @(negedge clk);
    poweron_req = 1'b0;
    repeat (10) @(negedge clk);
    poweron_req = 1'b1;
    repeat (2) @(negedge clk);
    poweron_req = 1'b0;
    nf += 2;
    wait_frames(nf, 600, "poedge_frames");
    repeat (400) @(negedge clk);
    chk("poedge_no_extra", 64'(frames_done), 64'(nf));
    chk("poedge_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of DATA
    kbd_data     = 16'h7E81;
    kbd_is_mouse = 1'b0;
    e = '{40'hC610007E81, SRC_KBD}; exp_q.push_back(e);
    exp_kbd_acks++;
    kbd_req = 1'b1;
    wait_ack(1'b0, 50, "rst_kbd_ack_seen");
    kbd_req = 1'b0;
    repeat ((1 + 20) * BIT_CLKS) @(negedge clk);
    chk("rst_mid_busy_before", 64'(busy), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_tx_out", 64'(tx_out), 64'd1);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_last_src", 64'(last_src), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    line_ok = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      line_ok &= (tx_out === 1'b1) && (busy === 1'b0);
    end
    chk("rst_line_idle", 64'(line_ok), 64'd1);
    chk("rst_no_resend", 64'(frames_done), 64'(nf));
    chk("rst_aborted", 64'(n_aborted), 64'd1);

    chk("total_kbd_acks", 64'(n_kbd_ack), 64'(exp_kbd_acks));
    chk("total_mic_acks", 64'(n_mic_ack), 64'(exp_mic_acks));
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/op_tx_scheduler.md
Name: op_tx_scheduler

Overview:
Transmit scheduler for the 40-bit opcode packets sent from the keyboard/sound interface to the host. It arbitrates among three sources: power-on announce, microphone record data and keyboard/mouse data. It builds the 40-bit packet for the winning source, acknowledges that requester, and serialises the packet MSB-first onto a single idle-high line. Start-bit framing and an enforced inter-packet gap are included.

Parameters:
BIT_CLKS, 4, clock cycles per serial bit; legal range 1..255.
GAP_BITS, 2, idle-high bit periods after the last data bit before the next start bit; legal range 1..15.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
poweron_req  in  1  level; each rising edge requests one power-on packet
kbd_req  in  1  keyboard/mouse packet pending; held until kbd_ack
kbd_is_mouse  in  1  selects mouse sub-code; stable while kbd_req is high
kbd_data  in  16  keyboard/mouse payload; stable while kbd_req is high
kbd_ack  out  1  one-cycle pulse: keyboard packet captured
mic_req  in  1  microphone packet pending; held until mic_ack
mic_data  in  32  microphone payload; stable while mic_req is high
mic_ack  out  1  one-cycle pulse: mic packet captured
tx_out  out  1  serial line, idle high
busy  out  1  high whenever state is not IDLE
last_src  out  2  source of the last captured packet: 0 none, 1 power-on, 2 mic, 3 kbd

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous and active-low.
- Reset values: state IDLE, tx_out 1, busy 0, kbd_ack 0, mic_ack 0, last_src 0, power-on pending flag 0, poweron_req edge register 0, round-robin pointer favours mic.
- Power-on edge detect: a registered copy of poweron_req is kept. Its rising edge sets the pending flag; the flag clears when the power-on packet is captured.
  - poweron_req high at reset release counts as one edge.
  - Edges during a frame are latched. Multiple edges before service collapse to one packet.
- Packet formats:
  - Power-on: 40'hC671000000.
  - Mic: {8'hC7, mic_data}.
  - Keyboard: {8'hC6, kbd_is_mouse ? 8'h01 : 8'h10, 8'h00, kbd_data}.
- Arbitration (evaluated only in IDLE):
  - Power-on pending has absolute priority.
  - Otherwise, if only one of mic_req/kbd_req is high, that source wins.
  - If both are high, the source not served last between them wins. The pointer updates only on mic/kbd grants.
- Capture: on the clock edge where IDLE sees a winner, the packet goes into a 40-bit shift register and the state goes to START.
  - In the next cycle: the winner's ack is 1 (exactly one cycle), last_src is updated, busy is 1, and tx_out is 0.
  - Requester may keep req high after ack to request a further packet. Data may change only after ack.
- States:
  - IDLE: tx_out 1. Go to START on a grant; otherwise stay.
  - START: tx_out 0 for BIT_CLKS cycles, then go to DATA.
  - DATA: tx_out = shift[39]. Shift left every BIT_CLKS cycles. After 40 bits, go to GAP.
  - GAP: tx_out 1 for GAP_BITS*BIT_CLKS cycles, then go to IDLE.
- Frame timing:
  - Capture edge to IDLE return: (41+GAP_BITS)*BIT_CLKS cycles.
  - Minimum spacing between consecutive start-bit falling edges: (41+GAP_BITS)*BIT_CLKS + 1 cycles (includes the one IDLE arbitration cycle).
- Counters: bit-time counter 8 bits, bit counter 6 bits (0..39), gap counter sized for GAP_BITS*BIT_CLKS. No wrap beyond terminal counts.
- Requests arriving in START/DATA/GAP are not acked until the next IDLE. A request dropped before ack is simply not served.
- Reset mid-frame:
  - tx_out returns to 1 immediately (asynchronous). The partial packet is discarded.
  - The source that was already acked is not re-sent.
  - The pending flag and edge register clear.

Test Plan:
- Single keyboard packet: BIT_CLKS=4, GAP_BITS=2; kbd_req=1, kbd_is_mouse=0, kbd_data=16'h1234 -> one kbd_ack pulse; tx_out shows start 0 then 40'hC610001234 MSB-first, 4 cycles/bit, then 8 cycles high; busy high for 172 cycles; last_src=3.
- Power-on priority: poweron_req rises while mic_req=1 and kbd_req=1 in IDLE -> first frame is 40'hC671000000 with no acks; mic is served next, then kbd (mic-first pointer at reset).
- Round-robin fairness: mic_req and kbd_req held high with changing data across 4 frames -> acks alternate mic, kbd, mic, kbd; frame starts spaced exactly 173 cycles apart.
- Mouse encoding: kbd_is_mouse=1, kbd_data=16'hFF01 -> serial payload 40'hC60100FF01.
- Power-on edge during frame: poweron_req pulses twice during a mic frame -> exactly one power-on frame follows the mic frame; no extra frame.
- Reset mid-DATA: rst_n low at bit 20 -> tx_out=1 immediately, busy=0; after release with no requests, tx_out stays 1 and no ack is issued.
